// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed program from a host byte channel
// into a ROM, verifies an 8-bit additive checksum, then releases the CPU.
//
// Host stream: N (0 = 256), N code bytes, checksum (sum of code bytes mod 256).
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   start             load request (honoured in IDLE, RUNNING, ERR)
//   in_valid/in_data  host byte; in_ready accepts it
//   rstROM            ROM clear pulse (CLEAR)
//   edit/unit/code/send  ROM programming bus; send is the write strobe
//   cpu_rst, RUN      CPU reset pulse / continuous-run request
//   busy, done, error load status; count = code bytes written this load
module program_loader #(
  parameter logic [7:0] BASE_ADDR   = 8'h00,
  parameter int         SEND_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       rstROM,
  output logic       edit,
  output logic [7:0] unit,
  output logic [7:0] code,
  output logic       send,
  output logic       cpu_rst,
  output logic       RUN,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] count
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_LEN, S_DATA, S_WRITE, S_CHECK, S_CPURST, S_RUNNING, S_ERR
  } state_e;

  localparam logic [1:0] SEND_LAST = 2'(SEND_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] unit_q, unit_d, code_q, code_d, count_q, count_d;
  logic [7:0] sum_q, sum_d, len_q, len_d;
  logic [1:0] scnt_q, scnt_d;
  logic       in_ready_q, in_ready_d, rstrom_q, rstrom_d, edit_q, edit_d;
  logic       send_q, send_d, cpu_rst_q, cpu_rst_d, run_q, run_d;
  logic       busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic       xfer;

  // in_ready_q always mirrors the current state, so this is the handshake.
  assign xfer = in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    code_d  = code_q;
    count_d = count_q;
    sum_d   = sum_q;
    len_d   = len_q;
    scnt_d  = scnt_q;
    case (state_q)
      S_IDLE, S_RUNNING, S_ERR: if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        count_d = 8'h00;
        sum_d   = 8'h00;
        unit_d  = BASE_ADDR;
        state_d = S_LEN;
      end
      S_LEN: if (xfer) begin
        len_d   = in_data;
        state_d = S_DATA;
      end
      S_DATA: if (xfer) begin
        code_d  = in_data;
        sum_d   = sum_q + in_data;
        scnt_d  = 2'd0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (scnt_q == SEND_LAST) begin
          unit_d  = unit_q + 8'd1;
          count_d = count_q + 8'd1;
          // len 0 means 256: the 8-bit count wraps back to 0 after 256 writes.
          state_d = (count_d == len_q) ? S_CHECK : S_DATA;
        end else begin
          scnt_d = scnt_q + 2'd1;
        end
      end
      S_CHECK: if (xfer) state_d = (in_data == sum_q) ? S_CPURST : S_ERR;
      S_CPURST: state_d = S_RUNNING;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with state_q and no input reaches an output combinationally.
  always_comb begin
    in_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHECK);
    rstrom_d   = (state_d == S_CLEAR);
    cpu_rst_d  = (state_d == S_CLEAR) || (state_d == S_CPURST);
    edit_d     = (state_d == S_DATA) || (state_d == S_WRITE);
    send_d     = (state_d == S_WRITE);
    run_d      = (state_d == S_RUNNING);
    done_d     = (state_d == S_RUNNING);
    error_d    = (state_d == S_ERR);
    busy_d     = (state_d != S_IDLE) && (state_d != S_RUNNING) && (state_d != S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      unit_q     <= BASE_ADDR;
      code_q     <= 8'h00;
      count_q    <= 8'h00;
      sum_q      <= 8'h00;
      len_q      <= 8'h00;
      scnt_q     <= 2'd0;
      in_ready_q <= 1'b0;
      rstrom_q   <= 1'b0;
      edit_q     <= 1'b0;
      send_q     <= 1'b0;
      cpu_rst_q  <= 1'b1;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_q     <= unit_d;
      code_q     <= code_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      len_q      <= len_d;
      scnt_q     <= scnt_d;
      in_ready_q <= in_ready_d;
      rstrom_q   <= rstrom_d;
      edit_q     <= edit_d;
      send_q     <= send_d;
      cpu_rst_q  <= cpu_rst_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready = in_ready_q;
  assign rstROM   = rstrom_q;
  assign edit     = edit_q;
  assign unit     = unit_q;
  assign code     = code_q;
  assign send     = send_q;
  assign cpu_rst  = cpu_rst_q;
  assign RUN      = run_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign count    = count_q;

endmodule
